// File: rtl/sseg_scan_capture.sv
// Recovers the digits of a multiplexed 7-segment display from its anode and segment lines
// and publishes them as one frame after a complete in-order 0..3 scan.
module sseg_scan_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] an,
    input  logic [6:0] sseg,
    input  logic       dp,
    output logic [6:0] seg0,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] seg3,
    output logic [3:0] val0,
    output logic [3:0] val1,
    output logic [3:0] val2,
    output logic [3:0] val3,
    output logic [3:0] dig_err,
    output logic [3:0] dp_on,
    output logic       frame_valid,
    output logic       seq_err
);

    typedef enum logic [1:0] {EXP0, EXP1, EXP2, EXP3} state_t;

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    state_t     state, state_next;
    logic [3:0] an_q, an_prev;
    logic [6:0] sseg_q;
    logic       dp_q;
    logic [7:0] run, run_next;
    logic       an_valid, capture;
    logic [1:0] cap_idx;
    logic       store_en, publish, seq_set;
    logic [6:0] sh_seg0, sh_seg1, sh_seg2;
    logic [2:0] sh_dp;

    // Returns {err, value}; unknown patterns decode to value 0 with err set.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h10:   r = 5'h09;
            7'h08:   r = 5'h0A;
            7'h03:   r = 5'h0B;
            7'h46:   r = 5'h0C;
            7'h21:   r = 5'h0D;
            7'h06:   r = 5'h0E;
            7'h0E:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    always_comb begin
        an_valid = 1'b1;
        cap_idx  = 2'd0;
        case (an_q)
            4'b1110: cap_idx = 2'd0;
            4'b1101: cap_idx = 2'd1;
            4'b1011: cap_idx = 2'd2;
            4'b0111: cap_idx = 2'd3;
            default: an_valid = 1'b0;
        endcase
    end

    always_comb begin
        run_next = '0;
        if (an_valid) begin
            if (an_q == an_prev)
                run_next = (run == 8'hFF) ? run : run + 8'd1;
            else
                run_next = 8'd1;
        end
    end

    // The old-run term keeps a saturated count (STABLE_CYCLES=255) from re-capturing.
    assign capture = an_valid && (run_next == STABLE) && (run != STABLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q    <= 4'hF;
            an_prev <= 4'hF;
            sseg_q  <= 7'h7F;
            dp_q    <= 1'b1;
            run     <= '0;
        end else begin
            an_q    <= an;
            an_prev <= an_q;
            sseg_q  <= sseg;
            dp_q    <= dp;
            run     <= run_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EXP0;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        store_en   = 1'b0;
        publish    = 1'b0;
        seq_set    = 1'b0;
        if (capture) begin
            if (cap_idx == 2'(state)) begin
                case (state)
                    EXP0:    begin store_en = 1'b1; state_next = EXP1; end
                    EXP1:    begin store_en = 1'b1; state_next = EXP2; end
                    EXP2:    begin store_en = 1'b1; state_next = EXP3; end
                    default: begin publish  = 1'b1; state_next = EXP0; end
                endcase
            end else begin
                seq_set = 1'b1;
                if (cap_idx == 2'd0) begin
                    store_en   = 1'b1;
                    state_next = EXP1;
                end else begin
                    state_next = EXP0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_seg0 <= 7'h7F;
            sh_seg1 <= 7'h7F;
            sh_seg2 <= 7'h7F;
            sh_dp   <= 3'b111;
        end else if (store_en) begin
            case (cap_idx)
                2'd0:    begin sh_seg0 <= sseg_q; sh_dp[0] <= dp_q; end
                2'd1:    begin sh_seg1 <= sseg_q; sh_dp[1] <= dp_q; end
                default: begin sh_seg2 <= sseg_q; sh_dp[2] <= dp_q; end
            endcase
        end
    end

    // Digit 3 goes straight from the input registers so the whole frame lands on one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg0        <= 7'h7F;
            seg1        <= 7'h7F;
            seg2        <= 7'h7F;
            seg3        <= 7'h7F;
            val0        <= '0;
            val1        <= '0;
            val2        <= '0;
            val3        <= '0;
            dig_err     <= '0;
            dp_on       <= '0;
            frame_valid <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            frame_valid <= publish;
            seq_err     <= seq_set;
            if (publish) begin
                seg0               <= sh_seg0;
                seg1               <= sh_seg1;
                seg2               <= sh_seg2;
                seg3               <= sseg_q;
                {dig_err[0], val0} <= decode(sh_seg0);
                {dig_err[1], val1} <= decode(sh_seg1);
                {dig_err[2], val2} <= decode(sh_seg2);
                {dig_err[3], val3} <= decode(sseg_q);
                dp_on              <= ~{dp_q, sh_dp};
            end
        end
    end

endmodule
